// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : PS/2 host-to-device byte transmitter (request-to-send, shift,
//             ACK check) driving open-collector CLK/DATA enables.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int START_HOLD_CYCLES  = 50,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int EDGE_TIMEOUT       = 100000,
    parameter int FILTER_LEN         = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int c_MAX_A = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int c_MAX_B = (FIRST_EDGE_TIMEOUT > EDGE_TIMEOUT) ? FIRST_EDGE_TIMEOUT : EDGE_TIMEOUT;
    localparam int c_TMAX  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_TW    = $clog2(c_TMAX + 1);
    localparam int c_FW    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t          r_state;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_filt;
    logic [c_FW-1:0] r_filt_cnt;
    logic            r_fall;
    logic [9:0]      r_frame;
    logic [3:0]      r_idx;
    logic [c_TW-1:0] r_timer;

    // Synchronizers and PS2_CLK glitch filter; idle bus level is high.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
                r_fall     <= ~r_clk_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_FW'(1);
            end
        end
    end

    // Frame bit 9 is the stop bit stored as 1 so every bit drives oe = ~bit.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            r_frame    <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_frame    <= {1'b1, ~^tx_data, tx_data};
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        r_timer    <= c_TW'(INHIBIT_CYCLES - 1);
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_timer == '0) begin
                        ps2_dat_oe <= 1'b1;
                        r_timer    <= c_TW'(START_HOLD_CYCLES - 1);
                        r_state    <= S_REQ;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                S_REQ: begin
                    if (r_timer == '0) begin
                        ps2_clk_oe <= 1'b0;
                        r_idx      <= '0;
                        r_timer    <= c_TW'(FIRST_EDGE_TIMEOUT);
                        r_state    <= S_SEND;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                S_SEND: begin
                    if (r_fall) begin
                        ps2_dat_oe <= ~r_frame[r_idx];
                        r_idx      <= r_idx + 4'd1;
                        r_timer    <= c_TW'(EDGE_TIMEOUT);
                        if (r_idx == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end else if (r_timer == '0) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        r_state    <= S_ERROR;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                S_ACK: begin
                    if (r_fall && !r_dat_s2) begin
                        r_timer <= c_TW'(EDGE_TIMEOUT);
                        r_state <= S_WAIT_IDLE;
                    end else if (r_fall || r_timer == '0) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        r_state    <= S_ERROR;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_clk_filt && r_dat_s2) begin
                        tx_done <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_timer == '0) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        r_state    <= S_ERROR;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
